decode_issue: RTL
=================

# decode_issue

Decode/issue stage for the rv32i core: accepts one instruction word plus PC per handshake, decodes it into the ALU control flags, immediate and opcode, reads operands from an internal 32×32 register file, and holds the result in a single output register consumed by the ALU stage. It also owns the register file write-back port. A per-register scoreboard stalls issue while a source register still has a result pending.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  fetch offers in_inst/in_pc
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  32  PC of in_inst
- out_valid  out  1  issue register holds an instruction
- out_ready  in  1  ALU stage consumes this cycle
- is_lui, is_i_type, is_branch  out  1 each  ALU class flags, at most one set
- alu_ops  out  4  ALU operation code
- rs1_data, rs2_data  out  32  operand values
- imm  out  32  decoded immediate
- pc_data  out  32  registered in_pc
- rd_addr  out  5  destination register
- rd_we  out  1  instruction writes rd (rd≠0)
- illegal_inst  out  1  undecodable instruction
- wb_en  in  1  write-back strobe
- wb_rd  in  5  write-back register
- wb_data  in  32  write-back value

## Operation
- Decode by opcode in_inst[6:0]:
  - 0110111 LUI: is_lui=1, imm={12'b0,inst[31:12]} (unshifted; ALU applies <<12), no sources, writes rd.
  - 0010011 OP-IMM: is_i_type=1, imm=sext(inst[31:20]), source rs1, writes rd; funct3 000→0000, 100→0010, 010→1000, 011→1011, else illegal.
  - 0110011 OP: sources rs1,rs2, writes rd; funct7 0000000: funct3 000→0000, 100→0010, 110→0011, 111→0100, 001→0101, 101→0110, 010→1001; funct7 0100000 with funct3 000→0001; funct7 0000001 see Configuration; else illegal.
  - 1100011 BRANCH: is_branch=1, imm=sext B-type {inst[31],inst[7],inst[30:25],inst[11:8],0}, sources rs1,rs2, no write.
  - Any other opcode/funct: illegal_inst=1, all flags 0, alu_ops=0, imm=0, rd_we=0, no sources.
- Register file: x0 reads 0, writes to x0 ignored. Read bypass: if wb_en and wb_rd equals a source register (≠0), that operand takes wb_data.
- Scoreboard busy[31:1]: set busy[rd] when an instruction with rd_we=1 is accepted into the issue register; clear busy[wb_rd] on wb_en. Same register set and cleared in one cycle: set wins.
- Hazard: a used source register with busy=1 and not being written back this cycle.
- in_ready = (!out_valid || out_ready) && !hazard (combinational from in_inst). Accept = in_valid && in_ready.
- Illegal instructions issue normally with illegal_inst=1; handling is downstream.

## Timing
- Latency 1: accepted in cycle N → out_valid and all outputs valid in cycle N+1.
- Full throughput: back-to-back accepts when out_ready=1 and no hazard.
- Outputs held stable while out_valid && !out_ready.
- Consume without accept: out_valid falls next cycle.
- Hazard stall: in_ready=0; released the cycle wb_en writes the blocking register (bypassed value issued).
- Reset: out_valid=0, all outputs 0, busy cleared, register file cleared to 0; an in-flight instruction is discarded; in_ready may be 1 the cycle after reset deasserts.

## Configuration
- RV32M_EN defined: OP funct7 0000001 with funct3 000→alu_ops 1100 (mul), 100→1101 (div); other funct3 illegal.
- RV32M_EN undefined: all funct7 0000001 encodings decode illegal.

## Test plan
- Reset, wb x1=7, x2=3; issue 0x002081B3 (add x3,x1,x2) → next cycle out_valid=1, alu_ops=0000, rs1_data=7, rs2_data=3, rd_addr=3, rd_we=1.
- Issue 0x123452B7 (lui x5) → is_lui=1, imm=0x00012345, rd_we=1; 0x402081B3 → alu_ops=0001.
- Issue 0xFE208CE3 (beq x1,x2,-8) at pc 0x100 → is_branch=1, imm=0xFFFFFFF8, pc_data=0x100, rd_we=0.
- Issue 0x00500093 (addi x1,x0,5), then add reading x1 → in_ready=0 until wb_en wb_rd=1 wb_data=5; that cycle accepted, rs1_data=5.
- Hold out_ready=0 two cycles → outputs unchanged, in_ready=0; 0x022081B3 → alu_ops=1100 with RV32M_EN, illegal_inst=1 without.
- Assert rst with out_valid=1 and busy set → next cycle out_valid=0, busy clear, x1 reads 0.

Source files
------------

// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// decode_issue : rv32i decode/issue stage with register file, scoreboard and
//                one-entry issue register. Optional M-extension decode: RV32M_EN
// Revision     : 1.0
// ============================================================================
module decode_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        is_lui,
    output logic        is_i_type,
    output logic        is_branch,
    output logic [3:0]  alu_ops,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] imm,
    output logic [31:0] pc_data,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic        illegal_inst,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    // instruction fields
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;

    // decode results
    logic        w_lui;
    logic        w_itype;
    logic        w_branch;
    logic        w_ill;
    logic        w_writes;
    logic        w_use1;
    logic        w_use2;
    logic [3:0]  w_op;
    logic [31:0] w_imm;
    logic        w_rd_we;

    // register file, scoreboard, handshake
    logic [31:0] r_rf [0:31];
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic        w_wb1;
    logic        w_wb2;
    logic        w_hazard;
    logic        w_ready;
    logic        w_accept;

    // issue register
    logic        r_valid;
    logic        r_lui;
    logic        r_itype;
    logic        r_branch;
    logic [3:0]  r_op;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic [4:0]  r_rd;
    logic        r_rd_we;
    logic        r_ill;

    assign w_opcode = in_inst[6:0];
    assign w_rd     = in_inst[11:7];
    assign w_f3     = in_inst[14:12];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];
    assign w_f7     = in_inst[31:25];

    always_comb begin
        w_lui    = 1'b0;
        w_itype  = 1'b0;
        w_branch = 1'b0;
        w_ill    = 1'b0;
        w_writes = 1'b0;
        w_use1   = 1'b0;
        w_use2   = 1'b0;
        w_op     = 4'b0000;
        w_imm    = 32'h0;
        case (w_opcode)
            c_OP_LUI: begin
                w_lui    = 1'b1;
                w_imm    = {12'h000, in_inst[31:12]};
                w_writes = 1'b1;
            end
            c_OP_IMM: begin
                w_itype  = 1'b1;
                w_imm    = {{20{in_inst[31]}}, in_inst[31:20]};
                w_use1   = 1'b1;
                w_writes = 1'b1;
                case (w_f3)
                    3'b000:  w_op = 4'b0000;
                    3'b100:  w_op = 4'b0010;
                    3'b010:  w_op = 4'b1000;
                    3'b011:  w_op = 4'b1011;
                    default: w_ill = 1'b1;
                endcase
            end
            c_OP_REG: begin
                w_use1   = 1'b1;
                w_use2   = 1'b1;
                w_writes = 1'b1;
                case (w_f7)
                    7'b0000000: begin
                        case (w_f3)
                            3'b000:  w_op = 4'b0000;
                            3'b100:  w_op = 4'b0010;
                            3'b110:  w_op = 4'b0011;
                            3'b111:  w_op = 4'b0100;
                            3'b001:  w_op = 4'b0101;
                            3'b101:  w_op = 4'b0110;
                            3'b010:  w_op = 4'b1001;
                            default: w_ill = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        if (w_f3 == 3'b000) begin
                            w_op = 4'b0001;
                        end else begin
                            w_ill = 1'b1;
                        end
                    end
                    7'b0000001: begin
`ifdef RV32M_EN
                        case (w_f3)
                            3'b000:  w_op = 4'b1100;
                            3'b100:  w_op = 4'b1101;
                            default: w_ill = 1'b1;
                        endcase
`else
                        w_ill = 1'b1;
`endif
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            c_OP_BRANCH: begin
                w_branch = 1'b1;
                w_imm    = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                            in_inst[30:25], in_inst[11:8], 1'b0};
                w_use1   = 1'b1;
                w_use2   = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        // an undecodable word issues as a bare marker: no class, no operands, no write
        if (w_ill) begin
            w_lui    = 1'b0;
            w_itype  = 1'b0;
            w_branch = 1'b0;
            w_writes = 1'b0;
            w_use1   = 1'b0;
            w_use2   = 1'b0;
            w_op     = 4'b0000;
            w_imm    = 32'h0;
        end
    end

    assign w_rd_we = w_writes && (w_rd != 5'd0);

    // operand read with same-cycle write-back bypass
    assign w_wb1 = wb_en && (wb_rd == w_rs1);
    assign w_wb2 = wb_en && (wb_rd == w_rs2);
    assign w_rd1 = (w_rs1 == 5'd0) ? 32'h0 : (w_wb1 ? wb_data : r_rf[w_rs1]);
    assign w_rd2 = (w_rs2 == 5'd0) ? 32'h0 : (w_wb2 ? wb_data : r_rf[w_rs2]);

    // busy[0] is never set, so x0 sources can never stall
    assign w_hazard = (w_use1 && r_busy[w_rs1] && !w_wb1) ||
                      (w_use2 && r_busy[w_rs2] && !w_wb2);
    assign w_ready  = (!r_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && w_ready;

    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        if (w_accept && w_rd_we) begin
            w_busy_nxt[w_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= 32'h0;
            end
            r_busy <= 32'h0;
        end else begin
            if (wb_en && (wb_rd != 5'd0)) begin
                r_rf[wb_rd] <= wb_data;
            end
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_lui    <= 1'b0;
            r_itype  <= 1'b0;
            r_branch <= 1'b0;
            r_op     <= 4'b0000;
            r_rs1    <= 32'h0;
            r_rs2    <= 32'h0;
            r_imm    <= 32'h0;
            r_pc     <= 32'h0;
            r_rd     <= 5'd0;
            r_rd_we  <= 1'b0;
            r_ill    <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_lui    <= w_lui;
            r_itype  <= w_itype;
            r_branch <= w_branch;
            r_op     <= w_op;
            r_rs1    <= w_rd1;
            r_rs2    <= w_rd2;
            r_imm    <= w_imm;
            r_pc     <= in_pc;
            r_rd     <= w_rd;
            r_rd_we  <= w_rd_we;
            r_ill    <= w_ill;
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign in_ready     = w_ready;
    assign out_valid    = r_valid;
    assign is_lui       = r_lui;
    assign is_i_type    = r_itype;
    assign is_branch    = r_branch;
    assign alu_ops      = r_op;
    assign rs1_data     = r_rs1;
    assign rs2_data     = r_rs2;
    assign imm          = r_imm;
    assign pc_data      = r_pc;
    assign rd_addr      = r_rd;
    assign rd_we        = r_rd_we;
    assign illegal_inst = r_ill;

endmodule
`default_nettype wire
